// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, operand mode codes and internal shift kinds for shift_pipe
package shift_pkg;
  localparam int SHIFT_WIDTH = 32;
  localparam int SHIFT_AMT_W = 8;
  typedef enum logic [3:0] {
    ROT_IMM8 = 4'd0,
    SH_LSL   = 4'd1,
    SH_LSR   = 4'd2,
    SH_ASR   = 4'd3,
    SH_ROR   = 4'd4,
    RS_LSL   = 4'd5,
    RS_LSR   = 4'd6,
    RS_ASR   = 4'd7,
    RS_ROR   = 4'd8,
    IMM12    = 4'd9,
    BR_IMM24 = 4'd10,
    DIR_RM   = 4'd11
  } shift_mode_t;
  typedef enum logic [2:0] {
    K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX
  } shift_kind_t;
endpackage

// File: rtl/barrel_core.sv
// barrel_core: combinational shifter; in kind/amt/op/c_in, out res/c
module barrel_core
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AW    = SHIFT_AMT_W
) (
  input  shift_kind_t      kind,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] op,
  input  logic             c_in,
  output logic [WIDTH-1:0] res,
  output logic             c
);
  localparam int LW = $clog2(WIDTH);
  logic        [WIDTH:0]   lsl_w;
  logic        [WIDTH:0]   lsr_w;
  logic signed [WIDTH:0]   asr_w;
  logic        [LW-1:0]    rot;
  logic        [WIDTH-1:0] ror_v;
  always_comb begin
    lsl_w = {1'b0, op} << amt;
    lsr_w = {op, 1'b0} >> amt;
    asr_w = $signed({op, 1'b0}) >>> amt;
    rot   = amt[LW-1:0];
    ror_v = (op >> rot) | (op << ((LW+1)'(WIDTH) - {1'b0, rot}));
    res = kind == K_LSL ? lsl_w[WIDTH-1:0] :
          kind == K_LSR ? lsr_w[WIDTH:1] :
          kind == K_ASR ? asr_w[WIDTH:1] :
          kind == K_ROR ? ror_v :
          kind == K_RRX ? {c_in, op[WIDTH-1:1]} : op;
    c   = kind == K_LSL ? lsl_w[WIDTH] :
          kind == K_LSR ? lsr_w[0] :
          kind == K_ASR ? asr_w[0] :
          kind == K_ROR ? ror_v[WIDTH-1] :
          kind == K_RRX ? op[0] : c_in;
  end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: 2-stage operand shifter; in valid/ready, mode, rm, rs, imm24, c_in; out src2, c_out, illegal
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AMT_W = SHIFT_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  shift_mode_t      mode,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] rs,
  input  logic [23:0]      imm24,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] src2,
  output logic             c_out,
  output logic             illegal
);
  localparam int AW = AMT_W > 7 ? AMT_W : 7;
  logic             unused_rs;
  logic             advance, load, mv;
  logic [4:0]       sh_a;
  logic [AMT_W-1:0] rs_a;
  logic [3:0]       rot;
  shift_kind_t      kind;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] op;
  logic             ill;
  logic             s1_valid_d, s1_valid_q, s1_cin_d, s1_cin_q, s1_ill_d, s1_ill_q;
  shift_kind_t      s1_kind_d, s1_kind_q;
  logic [AW-1:0]    s1_amt_d, s1_amt_q;
  logic [WIDTH-1:0] s1_op_d, s1_op_q;
  logic             out_valid_d, out_valid_q, c_out_d, c_out_q, illegal_d, illegal_q;
  logic [WIDTH-1:0] src2_d, src2_q, core_res;
  logic             core_c;
  assign unused_rs = ^rs[WIDTH-1:AMT_W];
  always_comb begin
    sh_a = imm24[11:7];
    rs_a = rs[AMT_W-1:0];
    rot  = imm24[11:8];
    kind = K_PASS;
    amt  = '0;
    op   = rm;
    ill  = 1'b0;
    case (mode)
      ROT_IMM8: begin
        op   = WIDTH'(imm24[7:0]);
        amt  = AW'({rot, 1'b0});
        kind = rot == 4'd0 ? K_PASS : K_ROR;
      end
      SH_LSL: begin
        amt  = AW'(sh_a);
        kind = sh_a == 5'd0 ? K_PASS : K_LSL;
      end
      SH_LSR: begin
        amt  = sh_a == 5'd0 ? AW'(WIDTH) : AW'(sh_a);
        kind = K_LSR;
      end
      SH_ASR: begin
        amt  = sh_a == 5'd0 ? AW'(WIDTH) : AW'(sh_a);
        kind = K_ASR;
      end
      SH_ROR: begin
        amt  = AW'(sh_a);
        kind = sh_a == 5'd0 ? K_RRX : K_ROR;
      end
      RS_LSL: begin
        amt  = AW'(rs_a);
        kind = rs_a == '0 ? K_PASS : K_LSL;
      end
      RS_LSR: begin
        amt  = AW'(rs_a);
        kind = rs_a == '0 ? K_PASS : K_LSR;
      end
      RS_ASR: begin
        amt  = AW'(rs_a);
        kind = rs_a == '0 ? K_PASS : K_ASR;
      end
      RS_ROR: begin
        amt  = AW'(rs_a);
        kind = rs_a == '0 ? K_PASS : K_ROR;
      end
      IMM12:    op = WIDTH'(imm24[11:0]);
      BR_IMM24: op = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
      DIR_RM:   op = rm;
      default:  ill = 1'b1;
    endcase
  end
  always_comb begin
    advance     = !out_valid_q || out_ready;
    in_ready    = !s1_valid_q || advance;
    load        = in_ready && in_valid;
    mv          = advance && s1_valid_q;
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_kind_d   = load ? kind : s1_kind_q;
    s1_amt_d    = load ? amt : s1_amt_q;
    s1_op_d     = load ? op : s1_op_q;
    s1_cin_d    = load ? c_in : s1_cin_q;
    s1_ill_d    = load ? ill : s1_ill_q;
    out_valid_d = advance ? s1_valid_q : out_valid_q;
    src2_d      = mv ? core_res : src2_q;
    c_out_d     = mv ? core_c : c_out_q;
    illegal_d   = mv ? s1_ill_q : illegal_q;
  end
  barrel_core #(.WIDTH(WIDTH), .AW(AW)) u_core (
    .kind (s1_kind_q),
    .amt  (s1_amt_q),
    .op   (s1_op_q),
    .c_in (s1_cin_q),
    .res  (core_res),
    .c    (core_c)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_kind_q   <= K_PASS;
      s1_amt_q    <= '0;
      s1_op_q     <= '0;
      s1_cin_q    <= 1'b0;
      s1_ill_q    <= 1'b0;
      out_valid_q <= 1'b0;
      src2_q      <= '0;
      c_out_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_kind_q   <= s1_kind_d;
      s1_amt_q    <= s1_amt_d;
      s1_op_q     <= s1_op_d;
      s1_cin_q    <= s1_cin_d;
      s1_ill_q    <= s1_ill_d;
      out_valid_q <= out_valid_d;
      src2_q      <= src2_d;
      c_out_q     <= c_out_d;
      illegal_q   <= illegal_d;
    end
  end
  assign out_valid = out_valid_q;
  assign src2      = src2_q;
  assign c_out     = c_out_q;
  assign illegal   = illegal_q;
endmodule
